// File: rtl/max_peak_search.sv
// max_peak_search: tracks the global peak (value, channel, bin) of the
// per-cycle maximum produced by max_parallel over a window of win_len bins,
// then reports it together with a threshold-detect flag.
// Optional: define MAX_PEAK_SECOND_EN to add second_val, the largest value
// seen in the window from a bin other than the peak bin.
module max_peak_search #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 10,
  parameter int BIN_W = 16,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] win_len,
  input  logic [WIDTH-1:0] threshold,
  input  logic             max_valid,
  input  logic [WIDTH-1:0] max_data,
  input  logic [CH_W-1:0]  max_ch,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] peak_val,
  output logic [CH_W-1:0]  peak_ch,
  output logic [BIN_W-1:0] peak_bin,
  output logic             detect
`ifdef MAX_PEAK_SECOND_EN
  ,
  output logic [WIDTH-1:0] second_val
`endif
);

  typedef enum logic [1:0] {IDLE, SEARCH, FINISH} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   win_len_q, win_len_d;
  logic [WIDTH-1:0]   thr_q, thr_d;
  logic [BIN_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   w_val_q, w_val_d;
  logic [CH_W-1:0]    w_ch_q, w_ch_d;
  logic [BIN_W-1:0]   w_bin_q, w_bin_d;
  logic [WIDTH-1:0]   peak_val_q, peak_val_d;
  logic [CH_W-1:0]    peak_ch_q, peak_ch_d;
  logic [BIN_W-1:0]   peak_bin_q, peak_bin_d;
  logic               detect_q, detect_d;
  logic               done_q, done_d;
  logic [BIN_W-1:0]   last_bin;
`ifdef MAX_PEAK_SECOND_EN
  logic [WIDTH-1:0]   w_sec_q, w_sec_d;
  logic [WIDTH-1:0]   sec_val_q, sec_val_d;
`endif

  assign last_bin = win_len_q - 1'b1;

  // State and working/result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      win_len_q  <= '0;
      thr_q      <= '0;
      cnt_q      <= '0;
      w_val_q    <= '0;
      w_ch_q     <= '0;
      w_bin_q    <= '0;
      peak_val_q <= '0;
      peak_ch_q  <= '0;
      peak_bin_q <= '0;
      detect_q   <= 1'b0;
      done_q     <= 1'b0;
`ifdef MAX_PEAK_SECOND_EN
      w_sec_q    <= '0;
      sec_val_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      win_len_q  <= win_len_d;
      thr_q      <= thr_d;
      cnt_q      <= cnt_d;
      w_val_q    <= w_val_d;
      w_ch_q     <= w_ch_d;
      w_bin_q    <= w_bin_d;
      peak_val_q <= peak_val_d;
      peak_ch_q  <= peak_ch_d;
      peak_bin_q <= peak_bin_d;
      detect_q   <= detect_d;
      done_q     <= done_d;
`ifdef MAX_PEAK_SECOND_EN
      w_sec_q    <= w_sec_d;
      sec_val_q  <= sec_val_d;
`endif
    end
  end

  // Next-state: window start, per-bin peak tracking, result publication
  always_comb begin
    state_d    = state_q;
    win_len_d  = win_len_q;
    thr_d      = thr_q;
    cnt_d      = cnt_q;
    w_val_d    = w_val_q;
    w_ch_d     = w_ch_q;
    w_bin_d    = w_bin_q;
    peak_val_d = peak_val_q;
    peak_ch_d  = peak_ch_q;
    peak_bin_d = peak_bin_q;
    detect_d   = detect_q;
    done_d     = 1'b0;
`ifdef MAX_PEAK_SECOND_EN
    w_sec_d    = w_sec_q;
    sec_val_d  = sec_val_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          win_len_d = win_len;
          thr_d     = threshold;
          cnt_d     = '0;
          w_val_d   = '0;
          w_ch_d    = '0;
          w_bin_d   = '0;
`ifdef MAX_PEAK_SECOND_EN
          w_sec_d   = '0;
`endif
          state_d   = (win_len == '0) ? FINISH : SEARCH;
        end
      end
      SEARCH: begin
        if (max_valid) begin
          cnt_d = cnt_q + 1'b1;
          // Bin 0 always loads so a window of all-zero data still reports its channel
          if (cnt_q == '0 || max_data > w_val_q) begin
            w_val_d = max_data;
            w_ch_d  = max_ch;
            w_bin_d = cnt_q;
`ifdef MAX_PEAK_SECOND_EN
            w_sec_d = w_val_q;
`endif
          end
`ifdef MAX_PEAK_SECOND_EN
          else if (max_data > w_sec_q) begin
            w_sec_d = max_data;
          end
`endif
          if (cnt_q == last_bin) state_d = FINISH;
        end
      end
      FINISH: begin
        peak_val_d = w_val_q;
        peak_ch_d  = w_ch_q;
        peak_bin_d = w_bin_q;
        detect_d   = (w_val_q >= thr_q);
        done_d     = 1'b1;
`ifdef MAX_PEAK_SECOND_EN
        sec_val_d  = w_sec_q;
`endif
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == SEARCH);
  assign done     = done_q;
  assign peak_val = peak_val_q;
  assign peak_ch  = peak_ch_q;
  assign peak_bin = peak_bin_q;
  assign detect   = detect_q;
`ifdef MAX_PEAK_SECOND_EN
  assign second_val = sec_val_q;
`endif

endmodule

// File: tb/tb_max_peak_search.sv
// Testbench for max_peak_search: directed table, hand-written corner
// sequences and randomized windows against a queue-based reference model.
module tb_max_peak_search;

  localparam int WIDTH = 8;
  localparam int N_CH  = 10;
  localparam int BIN_W = 16;
  localparam int CH_W  = 4;

  logic             clk = 1'b0;
  logic             rst, start, max_valid;
  logic [BIN_W-1:0] win_len;
  logic [WIDTH-1:0] threshold, max_data;
  logic [CH_W-1:0]  max_ch;
  logic             busy, done, detect;
  logic [WIDTH-1:0] peak_val;
  logic [CH_W-1:0]  peak_ch;
  logic [BIN_W-1:0] peak_bin;
`ifdef MAX_PEAK_SECOND_EN
  logic [WIDTH-1:0] second_val;
`endif

  always #5 clk = ~clk;

  max_peak_search #(.WIDTH(WIDTH), .N_CH(N_CH), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len),
    .threshold(threshold), .max_valid(max_valid), .max_data(max_data),
    .max_ch(max_ch), .busy(busy), .done(done), .peak_val(peak_val),
    .peak_ch(peak_ch), .peak_bin(peak_bin), .detect(detect)
`ifdef MAX_PEAK_SECOND_EN
    , .second_val(second_val)
`endif
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int unsigned exp_pv = 0, exp_pc = 0, exp_pb = 0, exp_det = 0, exp_sec = 0;

  typedef struct {
    string       name;
    int unsigned wl, thr, n;
    logic [7:0]  vld;
    logic [63:0] d;
    logic [31:0] c;
    bit          poke;
    int unsigned pv, pc, pb, det, sec;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".peak_val"}, 32'(peak_val), exp_pv);
    chk({tag, ".peak_ch"},  32'(peak_ch),  exp_pc);
    chk({tag, ".peak_bin"}, 32'(peak_bin), exp_pb);
    chk({tag, ".detect"},   32'(detect),   exp_det);
`ifdef MAX_PEAK_SECOND_EN
    chk({tag, ".second_val"}, 32'(second_val), exp_sec);
`endif
  endtask

  // Reference: peak = first occurrence of the maximum; second = maximum over all other bins
  function automatic void model(input logic [7:0] dq[$], input logic [3:0] cq[$], input int unsigned thr);
    int unsigned best;
    exp_pv = 0; exp_pc = 0; exp_pb = 0; exp_sec = 0;
    if (dq.size() != 0) begin
      best = 0;
      for (int i = 1; i < dq.size(); i++) if (dq[i] > dq[best]) best = i;
      exp_pv = dq[best]; exp_pc = cq[best]; exp_pb = best;
      for (int i = 0; i < dq.size(); i++)
        if (i != best && dq[i] > exp_sec) exp_sec = dq[i];
    end
    exp_det = (exp_pv >= thr) ? 1 : 0;
  endfunction

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      max_valid = 1'($urandom_range(0, 1));
      max_data  = 8'($urandom);
      max_ch    = 4'($urandom_range(0, 9));
      step();
    end
    max_valid = 1'b0;
    chk({tag, ".idle_busy"}, 32'(busy), 0);
    check_outputs({tag, ".idle_hold"});
  endtask

  task automatic run_window(input string tag, input int unsigned wl, input int unsigned thr,
                            input logic vq[$], input logic [7:0] dq[$], input logic [3:0] cq[$],
                            input bit poke, input bit have_exp,
                            input int unsigned pv, input int unsigned pc, input int unsigned pb,
                            input int unsigned det, input int unsigned sec);
    logic [7:0] ad[$];
    logic [3:0] ac[$];
    int d0;
    start = 1'b1; win_len = 16'(wl); threshold = 8'(thr); max_valid = 1'b0;
    step();
    start = 1'b0; win_len = 16'($urandom); threshold = 8'($urandom);
    d0 = done_cnt;
    chk({tag, ".busy_start"}, 32'(busy), (wl != 0) ? 1 : 0);
    check_outputs({tag, ".hold_prev"});
    for (int i = 0; i < vq.size(); i++) begin
      if (poke && i == 1) begin start = 1'b1; win_len = 16'd1; threshold = 8'd255; end
      else start = 1'b0;
      max_valid = vq[i]; max_data = dq[i]; max_ch = cq[i];
      step();
      if (vq[i]) begin ad.push_back(dq[i]); ac.push_back(cq[i]); end
    end
    start = 1'b0; max_valid = 1'b0;
    chk({tag, ".done_early"}, 32'(done_cnt - d0), 0);
    if (have_exp) begin
      exp_pv = pv; exp_pc = pc; exp_pb = pb; exp_det = det; exp_sec = sec;
    end else model(ad, ac, thr);
    step();
    chk({tag, ".done"}, 32'(done), 1);
    chk({tag, ".busy_end"}, 32'(busy), 0);
    check_outputs({tag, ".result"});
    step();
    chk({tag, ".done_pulse"}, 32'(done), 0);
    chk({tag, ".done_count"}, 32'(done_cnt - d0), 1);
    check_outputs({tag, ".hold"});
  endtask

  vec_t tbl[$];

  initial begin
    logic       vq[$];
    logic [7:0] dq[$];
    logic [3:0] cq[$];
    vec_t v;
    int unsigned wl, nv, d0;

    tbl.push_back('{"basic",   5,  50, 5, 8'b00011111, 64'h0000_0014_501E_500A, 32'h00094271, 1'b0,  80, 7, 1, 1,  80});
    tbl.push_back('{"gapped",  3, 200, 6, 8'b00101001, 64'h0000_03FA_09FA_FA05, 32'h00206003, 1'b0,   9, 6, 1, 0,   5});
    tbl.push_back('{"thr_eq",  2,  77, 2, 8'b00000011, 64'h0000_0000_0000_0A4D, 32'h00000010, 1'b0,  77, 0, 0, 1,  10});
    tbl.push_back('{"wl1",     1,   0, 1, 8'b00000001, 64'h0000_0000_0000_0000, 32'h00000009, 1'b0,   0, 9, 0, 1,   0});
    tbl.push_back('{"ascend",  4, 255, 4, 8'b00001111, 64'h0000_0000_FF03_0201, 32'h00008321, 1'b0, 255, 8, 3, 1,   3});
    tbl.push_back('{"descend", 3, 101, 3, 8'b00000111, 64'h0000_0000_0032_64C8, 32'h00000345, 1'b0, 200, 5, 0, 1, 100});
    tbl.push_back('{"zeros",   3,   1, 3, 8'b00000111, 64'h0000_0000_0000_0000, 32'h00000752, 1'b0,   0, 2, 0, 0,   0});
    tbl.push_back('{"wl0_t0",  0,   0, 0, 8'b00000000, 64'h0,                   32'h0,        1'b0,   0, 0, 0, 1,   0});
    tbl.push_back('{"wl0_t5",  0,   5, 0, 8'b00000000, 64'h0,                   32'h0,        1'b0,   0, 0, 0, 0,   0});
    tbl.push_back('{"busy_st", 3,   0, 3, 8'b00000111, 64'h0000_0000_0005_0604, 32'h00000321, 1'b1,   6, 2, 1, 1,   5});

    rst = 1'b1; start = 1'b0; win_len = '0; threshold = '0;
    max_valid = 1'b0; max_data = '0; max_ch = '0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("reset.busy", 32'(busy), 0);
      chk("reset.done", 32'(done), 0);
      chk("reset.peak_val", 32'(peak_val), 0);
      chk("reset.detect", 32'(detect), 0);
    end

    foreach (tbl[k]) begin
      v = tbl[k];
      vq.delete(); dq.delete(); cq.delete();
      for (int i = 0; i < v.n; i++) begin
        vq.push_back(v.vld[i]); dq.push_back(v.d[8*i +: 8]); cq.push_back(v.c[4*i +: 4]);
      end
      run_window(v.name, v.wl, v.thr, vq, dq, cq, v.poke, 1'b1, v.pv, v.pc, v.pb, v.det, v.sec);
      idle(2, v.name);
    end

    // Sample presented in the start cycle is not part of the window
    d0 = done_cnt;
    start = 1'b1; win_len = 16'd2; threshold = 8'd15;
    max_valid = 1'b1; max_data = 8'd200; max_ch = 4'd3;
    step();
    start = 1'b0; max_data = 8'd10; max_ch = 4'd1;
    step();
    max_data = 8'd20; max_ch = 4'd2;
    step();
    max_valid = 1'b0;
    chk("startvld.done_early", 32'(done_cnt - d0), 0);
    step();
    exp_pv = 20; exp_pc = 2; exp_pb = 1; exp_det = 1; exp_sec = 10;
    chk("startvld.done", 32'(done), 1);
    check_outputs("startvld");

    // Reset in the middle of a 4-bin window aborts with no done
    idle(2, "prerst");
    d0 = done_cnt;
    start = 1'b1; win_len = 16'd4; threshold = 8'd0;
    step();
    start = 1'b0; max_valid = 1'b1; max_data = 8'd100; max_ch = 4'd5;
    step();
    max_data = 8'd120;
    step();
    max_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_pv = 0; exp_pc = 0; exp_pb = 0; exp_det = 0; exp_sec = 0;
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.done", 32'(done), 0);
    check_outputs("midrst");
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("midrst.no_done", 32'(done_cnt - d0), 0);
    check_outputs("midrst.after");

    // Randomized windows against the reference model
    for (int t = 0; t < 40; t++) begin
      vq.delete(); dq.delete(); cq.delete();
      wl = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      nv = 0;
      while (nv < wl) begin
        vq.push_back(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        if (vq[vq.size()-1]) nv++;
        dq.push_back(($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3) * 64) : 8'($urandom));
        cq.push_back(4'($urandom_range(0, 9)));
      end
      run_window("rand", wl, $urandom_range(0, 255), vq, dq, cq,
                 ($urandom_range(0, 3) == 0), 1'b0, 0, 0, 0, 0, 0);
      idle($urandom_range(1, 4), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
